// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and sizing helpers for the FIFO read-side packer.
// The FIFO word width defaults to `DSIZE; it falls back to 8 when the build does not define it.
`ifndef DSIZE
`define DSIZE 8
`endif

package fifo_pkg;

    localparam int DSIZE_DEF = `DSIZE;

    typedef enum logic {FILL, HOLD} pk_state_e;

    // Lane-index width; a single-lane packer still needs a 1-bit index.
    function automatic int idx_width(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-beat valid/ready channel of the read-side packer.
interface fifo_rd_packer_if
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int PACK  = 4
);
    localparam int CW = $clog2(PACK + 1);

    logic                  rempty;
    logic [DSIZE-1:0]      rdata;
    logic                  rinc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DSIZE*PACK-1:0] out_data;
    logic [CW-1:0]         out_cnt;

    modport master (
        input  rempty, rdata, out_ready,
        output rinc, out_valid, out_data, out_cnt
    );

    modport slave (
        output rempty, rdata, out_ready,
        input  rinc, out_valid, out_data, out_cnt
    );

endinterface

// File: rtl/fifo_rd_packer_timeout.sv
// Idle counter for partial-beat flush: expire is asserted on the TO_CYCLES-th consecutive idle cycle.
module fifo_pack_timeout #(
    parameter int TO_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    output logic expire
);
    localparam int TW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    logic [TW-1:0] cnt;

    // Any non-idle cycle (a pop, or leaving FILL) restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !idle) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

    assign expire = idle && (cnt == TW'(TO_CYCLES - 1));

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs PACK words into one beat behind a valid/ready handshake.
// Define FIFO_PACK_FLUSH_EN to flush a partial beat after TO_CYCLES idle cycles.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int PACK      = 4,
    parameter int TO_CYCLES = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    fifo_rd_packer_if.master bus
);
    localparam int IW = idx_width(PACK);
    localparam int CW = $clog2(PACK + 1);

    if (PACK < 1 || PACK > 16 || TO_CYCLES < 1) begin : g_param_check
        $error("fifo_rd_packer: PACK must be 1..16 and TO_CYCLES >= 1");
    end

    pk_state_e                  state, state_n;
    logic [IW-1:0]              idx, idx_n;
    logic [PACK-1:0][DSIZE-1:0] lanes, lanes_n;
    logic [CW-1:0]              cnt, cnt_n;
    logic                       rinc;
    logic                       flush;

`ifdef FIFO_PACK_FLUSH_EN
    logic idle;

    assign idle = (state == FILL) && (idx != '0) && bus.rempty;

    fifo_pack_timeout #(.TO_CYCLES(TO_CYCLES)) u_timeout (
        .clk    (rclk),
        .rst    (rrst),
        .idle   (idle),
        .expire (flush)
    );
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        state_n = state;
        idx_n   = idx;
        lanes_n = lanes;
        cnt_n   = cnt;
        rinc    = 1'b0;
        unique case (state)
            FILL: begin
                rinc = !bus.rempty && !rrst;
                if (!bus.rempty) begin
                    lanes_n[idx] = bus.rdata;
                    if (idx == IW'(PACK - 1)) begin
                        state_n = HOLD;
                        cnt_n   = CW'(PACK);
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else if (flush) begin
                    state_n = HOLD;
                    cnt_n   = CW'(idx);
                    idx_n   = '0;
                end
            end
            HOLD: begin
                // The next word is taken only in the accept cycle, so a presented beat is never overwritten.
                rinc = !bus.rempty && bus.out_ready && !rrst;
                if (bus.out_ready) begin
                    state_n = FILL;
                    lanes_n = '0;
                    cnt_n   = '0;
                    idx_n   = '0;
                    if (!bus.rempty) begin
                        lanes_n[0] = bus.rdata;
                        if (PACK == 1) begin
                            state_n = HOLD;
                            cnt_n   = CW'(PACK);
                        end else begin
                            idx_n = IW'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rclk) begin
        // NOTE: the lane registers are reset too, because out_data must read 0 out of reset.
        if (rrst) begin
            state <= FILL;
            idx   <= '0;
            lanes <= '0;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state <= state_n;
            idx   <= idx_n;
            lanes <= lanes_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.rinc      = rinc;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = lanes;
    assign bus.out_cnt   = cnt;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: queue-based FIFO model plus a word-order scoreboard for packed beats.
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    localparam int DSIZE     = DSIZE_DEF;
    localparam int PACK      = 4;
    localparam int TO_CYCLES = 16;
    localparam int CW        = $clog2(PACK + 1);
    localparam int BW        = DSIZE * PACK;

    logic rclk = 1'b0;
    logic rrst = 1'b1;

    fifo_rd_packer_if #(.DSIZE(DSIZE), .PACK(PACK)) bus ();

    fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK), .TO_CYCLES(TO_CYCLES)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad   = 0;

    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] exp_q[$];
    int               beats = 0;
    int               pops = 0;
    int               cyc = 0;
    int               flush_cnt = 0;
    int               last_accept_cyc = 0;
    bit               popped;
    bit               accepted;
    bit               hold_prev = 1'b0;
    logic [BW-1:0]    prev_data;
    logic [CW-1:0]    prev_cnt;
    logic [BW-1:0]    last_beat;

    task automatic push(input logic [DSIZE-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One clock of the FIFO model and monitor: drive at negedge, sample 1 time unit later.
    task automatic run_cycle(input bit ready);
        logic [BW-1:0] exp_data;
        int            n;
        @(negedge rclk);
        bus.out_ready = ready;
        bus.rempty    = (fifo_q.size() == 0);
        bus.rdata     = (fifo_q.size() == 0) ? DSIZE'($urandom) : fifo_q[0];
        #1;
        cyc++;
        popped   = bus.rinc;
        accepted = bus.out_valid && ready;
        total++;
        if (bus.rinc && bus.rempty) begin
            bad++;
            $display("FAIL pop_while_empty: rinc=%0b rempty=%0b, required rinc=0 (cycle %0d)", bus.rinc, bus.rempty, cyc);
        end
        if (hold_prev) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_cnt !== prev_cnt) begin
                bad++;
                $display("FAIL hold_stable: valid=%0b data=%h cnt=%0d, required valid=1 data=%h cnt=%0d (cycle %0d)",
                         bus.out_valid, bus.out_data, bus.out_cnt, prev_data, prev_cnt, cyc);
            end
        end
        if (accepted) begin
            n        = (flush_cnt != 0) ? flush_cnt : PACK;
            exp_data = '0;
            total++;
            if (exp_q.size() < n) begin
                bad++;
                $display("FAIL unexpected_beat: data=%h cnt=%0d, required no beat with %0d words pending (cycle %0d)",
                         bus.out_data, bus.out_cnt, exp_q.size(), cyc);
            end else begin
                for (int i = 0; i < n; i++) exp_data[i*DSIZE +: DSIZE] = exp_q.pop_front();
                if (bus.out_data !== exp_data || bus.out_cnt !== CW'(n)) begin
                    bad++;
                    $display("FAIL beat: data=%h cnt=%0d, required data=%h cnt=%0d (cycle %0d)",
                             bus.out_data, bus.out_cnt, exp_data, n, cyc);
                end
            end
            beats++;
            last_beat       = bus.out_data;
            last_accept_cyc = cyc;
        end
        hold_prev = bus.out_valid && !ready;
        prev_data = bus.out_data;
        prev_cnt  = bus.out_cnt;
        if (popped && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst          = 1'b1;
        bus.rempty    = 1'b1;
        bus.out_ready = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        hold_prev = 1'b0;
        repeat (2) @(negedge rclk);
        rrst = 1'b0;
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(DSIZE'($urandom));
        for (int i = 0; i < 6; i++) begin
            @(negedge rclk);
            bus.rempty    = 1'b0;
            bus.rdata     = fifo_q[0];
            bus.out_ready = 1'b1;
            #1;
            total++;
            if (bus.rinc !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_cnt !== '0) begin
                bad++;
                $display("FAIL reset_state: rinc=%0b valid=%0b data=%h cnt=%0d, required all 0",
                         bus.rinc, bus.out_valid, bus.out_data, bus.out_cnt);
            end
        end
    endtask

    task automatic test_basic();
        int b0 = beats;
        push(DSIZE'(8'h11));
        push(DSIZE'(8'h22));
        push(DSIZE'(8'h33));
        push(DSIZE'(8'h44));
        for (int i = 0; i < 20 && beats == b0; i++) run_cycle(1'b1);
        total++;
        if (beats !== b0 + 1 || last_beat !== {DSIZE'(8'h44), DSIZE'(8'h33), DSIZE'(8'h22), DSIZE'(8'h11)}) begin
            bad++;
            $display("FAIL basic_pack: beats=%0d data=%h, required beats=%0d data=44332211", beats - b0, last_beat, 1);
        end
    endtask

    task automatic test_backpressure();
        int b0 = beats;
        int p0 = pops;
        for (int i = 1; i <= 8; i++) push(DSIZE'(8'h50 + i));
        repeat (10) run_cycle(1'b0);
        total++;
        if (pops - p0 !== 4 || beats !== b0) begin
            bad++;
            $display("FAIL bp_pops: pops=%0d beats=%0d, required pops=4 beats=0", pops - p0, beats - b0);
        end
        run_cycle(1'b1);
        total++;
        if (popped !== 1'b1 || accepted !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept_pop: popped=%0b accepted=%0b, required both 1", popped, accepted);
        end
        for (int i = 0; i < 20 && beats < b0 + 2; i++) run_cycle(1'b1);
        total++;
        if (beats !== b0 + 2 || pops - p0 !== 8) begin
            bad++;
            $display("FAIL bp_drain: beats=%0d pops=%0d, required beats=2 pops=8", beats - b0, pops - p0);
        end
    endtask

    task automatic test_streaming();
        int b0 = beats;
        int prev_acc = -1;
        int max_gap = 0;
        for (int i = 0; i < 64; i++) push(DSIZE'($urandom));
        for (int i = 0; i < 200 && beats < b0 + 16; i++) begin
            run_cycle(1'b1);
            if (accepted) begin
                if (prev_acc >= 0 && cyc - prev_acc > max_gap) max_gap = cyc - prev_acc;
                prev_acc = cyc;
            end
        end
        total++;
        if (beats !== b0 + 16 || fifo_q.size() !== 0) begin
            bad++;
            $display("FAIL stream_count: beats=%0d left=%0d, required beats=16 left=0", beats - b0, fifo_q.size());
        end
        total++;
        if (max_gap !== PACK) begin
            bad++;
            $display("FAIL stream_gap: max_gap=%0d, required %0d", max_gap, PACK);
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        int p0 = pops;
        push(DSIZE'(8'hE1));
        push(DSIZE'(8'hE2));
        repeat (3) run_cycle(1'b1);
        total++;
        if (pops - p0 !== 2) begin
            bad++;
            $display("FAIL mid_pre_pops: pops=%0d, required 2", pops - p0);
        end
        do_reset();
        b0 = beats;
        push(DSIZE'(8'hA1));
        push(DSIZE'(8'hA2));
        push(DSIZE'(8'hA3));
        push(DSIZE'(8'hA4));
        for (int i = 0; i < 20 && beats == b0; i++) run_cycle(1'b1);
        total++;
        if (beats !== b0 + 1 || last_beat !== {DSIZE'(8'hA4), DSIZE'(8'hA3), DSIZE'(8'hA2), DSIZE'(8'hA1)}) begin
            bad++;
            $display("FAIL mid_reset_beat: beats=%0d data=%h, required beats=1 data=a4a3a2a1", beats - b0, last_beat);
        end
    endtask

    task automatic test_flush();
        int b0 = beats;
        int c0 = cyc;
        push(DSIZE'(8'hAA));
        push(DSIZE'(8'hBB));
`ifdef FIFO_PACK_FLUSH_EN
        flush_cnt = 2;
        for (int i = 0; i < 60 && beats == b0; i++) run_cycle(1'b1);
        flush_cnt = 0;
        total++;
        if (beats !== b0 + 1 || last_beat !== BW'({DSIZE'(8'hBB), DSIZE'(8'hAA)})) begin
            bad++;
            $display("FAIL flush_beat: beats=%0d data=%h, required beats=1 data=0000bbaa", beats - b0, last_beat);
        end
        total++;
        if (last_accept_cyc - c0 !== 2 + TO_CYCLES + 1) begin
            bad++;
            $display("FAIL flush_timing: accept at +%0d, required +%0d", last_accept_cyc - c0, 2 + TO_CYCLES + 1);
        end
`else
        repeat (40) run_cycle(1'b1);
        total++;
        if (beats !== b0) begin
            bad++;
            $display("FAIL partial_wait: beats=%0d, required 0", beats - b0);
        end
        push(DSIZE'(8'hCC));
        push(DSIZE'(8'hDD));
        for (int i = 0; i < 20 && beats == b0; i++) run_cycle(1'b1);
        total++;
        if (beats !== b0 + 1 || last_beat !== {DSIZE'(8'hDD), DSIZE'(8'hCC), DSIZE'(8'hBB), DSIZE'(8'hAA)}) begin
            bad++;
            $display("FAIL partial_complete: beats=%0d data=%h, required beats=1 data=ddccbbaa", beats - b0, last_beat);
        end
`endif
    endtask

    task automatic test_random();
        int b0 = beats;
        int pushed = 0;
        int since = 0;
        for (int i = 0; i < 3000 && beats < b0 + 16; i++) begin
            if (pushed < 64 && ($urandom_range(0, 1) == 1 || since >= 6)) begin
                push(DSIZE'($urandom));
                pushed++;
                since = 0;
            end else begin
                since++;
            end
            run_cycle($urandom_range(0, 3) != 0);
        end
        total++;
        if (beats !== b0 + 16 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL random_drain: beats=%0d pending=%0d, required beats=16 pending=0", beats - b0, exp_q.size());
        end
    endtask

    initial begin
        bus.rempty    = 1'b1;
        bus.rdata     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        do_reset();
        test_basic();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
